// File: rtl/video_axis_pkg.sv
// Shared constants and FSM state type for the AXI4-Stream video alignment blocks.
package video_axis_pkg;

  localparam int unsigned TUSER_SOF = 0;
  localparam int unsigned TUSER_EOF = 1;
  localparam int unsigned RES_W     = 12;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered output stage: full throughput, ready depends only on local state.
module axis_skid_buffer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             a_valid_q, b_valid_q;
  logic [Width-1:0] a_data_q, b_data_q;
  logic             pop;

  assign pop = a_valid_q & out_ready;

  // Entry a drives the output; entry b only fills when a is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else if (pop) begin
      if (b_valid_q) begin
        a_data_q  <= b_data_q;
        b_valid_q <= 1'b0;
      end else begin
        a_valid_q <= in_valid;
        if (in_valid) a_data_q <= in_data;
      end
    end else if (!a_valid_q) begin
      a_valid_q <= in_valid;
      if (in_valid) a_data_q <= in_data;
    end else if (in_valid) begin
      b_valid_q <= 1'b1;
      b_data_q  <= in_data;
    end
  end

  assign in_ready  = ~b_valid_q;
  assign out_valid = a_valid_q;
  assign out_data  = a_data_q;

endmodule

// File: rtl/axis_frame_aligner.sv
// Regenerates SOF/EOL/EOF from counters and discards malformed frames.
// FRAME_ALIGNER_STATS_EN builds the drop counter and sticky sync-lost flag.
module axis_frame_aligner
  import video_axis_pkg::*;
#(
  parameter int unsigned C_WIDTH       = 8,
  parameter int unsigned PIXEL_PER_CLK = 1,
  parameter int unsigned TUSER_WIDTH   = 2
) (
  input  logic                                 i_axis_clk,
  input  logic                                 i_axis_reset,
  input  logic [RES_W-1:0]                     i_hres,
  input  logic [RES_W-1:0]                     i_vres,
  input  logic [PIXEL_PER_CLK*3*C_WIDTH-1:0]   s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]               s_axis_tuser,
  output logic [PIXEL_PER_CLK*3*C_WIDTH-1:0]   m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic [15:0]                          o_frames_dropped,
  output logic                                 o_sync_lost
);

  localparam int unsigned DW = PIXEL_PER_CLK * 3 * C_WIDTH;
  localparam int unsigned PW = DW + 1 + TUSER_WIDTH;
  localparam logic [RES_W-1:0] ResOne = RES_W'(1);

  state_e           state_q, state_d;
  logic [RES_W-1:0] hres_q, hres_d, vres_q, vres_d;
  logic [RES_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             replay_q, replay_d;
  logic [DW-1:0]    rp_data_q;
  logic             rp_last_q;
  logic [TUSER_WIDTH-1:0] rp_user_q;

  logic                   skid_ready, accept, start, adv;
  logic [DW-1:0]          beat_data;
  logic                   beat_last;
  logic [TUSER_WIDTH-1:0] beat_user;
  logic [RES_W-1:0]       cur_h, cur_v, cur_hres, cur_vres;
  logic                   last_h, last_beat;
  logic                   fwd, fwd_last, drop_evt;
  logic [TUSER_WIDTH-1:0] fwd_user;

  // A stray SOF is parked in the replay register and re-presented as a fresh SOF.
  assign s_axis_tready = skid_ready & ~replay_q & ~i_axis_reset;
  assign beat_data     = replay_q ? rp_data_q : s_axis_tdata;
  assign beat_last     = replay_q ? rp_last_q : s_axis_tlast;
  assign beat_user     = replay_q ? rp_user_q : s_axis_tuser;
  assign accept        = (replay_q | s_axis_tvalid) & skid_ready & ~i_axis_reset;

  always_comb begin
    state_d  = state_q;
    hres_d   = hres_q;
    vres_d   = vres_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    replay_d = replay_q & ~accept;
    fwd      = 1'b0;
    adv      = 1'b0;
    drop_evt = 1'b0;
    fwd_user = '0;

    start     = (state_q != PASS) && beat_user[TUSER_SOF];
    cur_h     = start ? '0 : h_cnt_q;
    cur_v     = start ? '0 : v_cnt_q;
    cur_hres  = start ? i_hres : hres_q;
    cur_vres  = start ? i_vres : vres_q;
    last_h    = (cur_h == cur_hres - ResOne);
    last_beat = last_h && (cur_v == cur_vres - ResOne);

    fwd_last            = last_h;
    fwd_user[TUSER_SOF] = (cur_h == '0) && (cur_v == '0);
    fwd_user[TUSER_EOF] = last_beat;

    if (accept) begin
      unique case (state_q)
        IDLE, DROP: begin
          if (start) begin
            hres_d  = i_hres;
            vres_d  = i_vres;
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (i_hres == '0 || i_vres == '0) begin
              drop_evt = 1'b1;
              state_d  = DROP;
            end else begin
              fwd     = 1'b1;
              adv     = 1'b1;
              state_d = last_beat ? IDLE : PASS;
            end
          end
        end
        PASS: begin
          if (beat_user[TUSER_SOF] && !fwd_user[TUSER_SOF]) begin
            drop_evt = 1'b1;
            replay_d = 1'b1;
            state_d  = DROP;
          end else if ((beat_last != last_h) || (beat_user[TUSER_EOF] && !last_beat)) begin
            fwd                 = 1'b1;
            fwd_last            = 1'b1;
            fwd_user[TUSER_EOF] = 1'b1;
            drop_evt            = 1'b1;
            state_d             = DROP;
          end else begin
            fwd     = 1'b1;
            adv     = 1'b1;
            state_d = last_beat ? IDLE : PASS;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (adv) begin
      if (last_h) begin
        h_cnt_d = '0;
        v_cnt_d = cur_v + ResOne;
      end else begin
        h_cnt_d = cur_h + ResOne;
        v_cnt_d = cur_v;
      end
    end
  end

  always_ff @(posedge i_axis_clk) begin
    if (i_axis_reset) begin
      state_q   <= IDLE;
      hres_q    <= '0;
      vres_q    <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      replay_q  <= 1'b0;
      rp_data_q <= '0;
      rp_last_q <= 1'b0;
      rp_user_q <= '0;
    end else begin
      state_q  <= state_d;
      hres_q   <= hres_d;
      vres_q   <= vres_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      replay_q <= replay_d;
      if (replay_d && !replay_q) begin
        rp_data_q <= s_axis_tdata;
        rp_last_q <= s_axis_tlast;
        rp_user_q <= s_axis_tuser;
      end
    end
  end

  axis_skid_buffer #(
    .Width(PW)
  ) u_skid (
    .clk      (i_axis_clk),
    .rst      (i_axis_reset),
    .in_valid (fwd),
    .in_ready (skid_ready),
    .in_data  ({beat_data, fwd_last, fwd_user}),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data ({m_axis_tdata, m_axis_tlast, m_axis_tuser})
  );

`ifdef FRAME_ALIGNER_STATS_EN
  logic [15:0] frames_dropped_q;
  logic        sync_lost_q;

  always_ff @(posedge i_axis_clk) begin
    if (i_axis_reset) begin
      frames_dropped_q <= '0;
      sync_lost_q      <= 1'b0;
    end else if (drop_evt) begin
      if (frames_dropped_q != 16'hFFFF) frames_dropped_q <= frames_dropped_q + 16'd1;
      sync_lost_q <= 1'b1;
    end
  end

  assign o_frames_dropped = frames_dropped_q;
  assign o_sync_lost      = sync_lost_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt  = drop_evt;
  assign o_frames_dropped = '0;
  assign o_sync_lost      = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_aligner.sv
// Directed self-checking bench for axis_frame_aligner (RGB 8-bit, 1 pixel per beat).
module tb_axis_frame_aligner;

`ifdef FRAME_ALIGNER_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] i_hres = '0, i_vres = '0;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [1:0]  s_tuser = '0;
  logic        s_tready;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [1:0]  m_tuser;
  logic [15:0] o_frames_dropped;
  logic        o_sync_lost;

  int    vectors = 0, errors = 0, stall_err = 0;
  beat_t out_q[$], exp_q[$];
  beat_t prev_beat;
  logic  prev_stall = 1'b0;
  bit    done;

  always #5 clk = ~clk;

  axis_frame_aligner dut (
    .i_axis_clk      (clk),
    .i_axis_reset    (rst),
    .i_hres          (i_hres),
    .i_vres          (i_vres),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser    (m_tuser),
    .o_frames_dropped(o_frames_dropped),
    .o_sync_lost     (o_sync_lost)
  );

  // Output capture plus hold-while-stalled monitoring.
  always @(negedge clk) begin
    if (prev_stall && (!m_tvalid || {m_tdata, m_tlast, m_tuser} !== prev_beat)) stall_err++;
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = {m_tdata, m_tlast, m_tuser};
    if (m_tvalid && m_tready) out_q.push_back({m_tdata, m_tlast, m_tuser});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Well-formed beat i of an h x v frame.
  function automatic beat_t in_beat(input int h, input int v, input int i, input logic [7:0] tag);
    beat_t b;
    b.data = {tag, 16'(i)};
    b.last = ((i % h) == h - 1);
    b.user = {i == h * v - 1, i == 0};
    return b;
  endfunction

  task automatic send(input beat_t b, input int budget, output int waited);
    logic acc;
    int   n = 0;
    s_tdata  = b.data;
    s_tlast  = b.last;
    s_tuser  = b.user;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < budget);
    s_tvalid = 1'b0;
    waited   = n;
    vectors++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: beat %h not accepted within %0d cycles", b, budget);
    end
  endtask

  task automatic send_range(input int h, input int v, input logic [7:0] tag,
                            input int from, input int to);
    int w;
    i_hres = 12'(h);
    i_vres = 12'(v);
    for (int i = from; i <= to; i++) send(in_beat(h, v, i, tag), 60, w);
  endtask

  task automatic add_exp(input int h, input int v, input logic [7:0] tag,
                         input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back(in_beat(h, v, i, tag));
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    vectors++;
    if ({m_tdata, m_tlast, m_tuser} !== 27'd0) begin
      errors++; $display("FAIL reset_payload: got %h want 0", {m_tdata, m_tlast, m_tuser});
    end
    vectors++; if (o_frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %h want 0", o_frames_dropped); end
    vectors++; if (o_sync_lost !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", o_sync_lost); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready: got %b want 1", s_tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean_frame();
    int w;
    out_q.delete(); exp_q.delete();
    i_hres = 12'd4; i_vres = 12'd3;
    send(in_beat(4, 3, 0, 8'h11), 4, w);
    vectors++;
    if (m_tvalid !== 1'b1 || m_tuser !== 2'b01 || m_tdata !== 24'h110000) begin
      errors++; $display("FAIL clean_latency: got v=%b u=%b d=%h want v=1 u=01 d=110000",
                         m_tvalid, m_tuser, m_tdata);
    end
    send_range(4, 3, 8'h11, 1, 11);
    drain();
    add_exp(4, 3, 8'h11, 0, 11);
    vectors++; if (out_q.size() != 12) begin errors++; $display("FAIL clean_count: got %0d want 12", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL clean_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (o_frames_dropped !== 16'd0) begin errors++; $display("FAIL clean_dropped: got %h want 0", o_frames_dropped); end
    vectors++; if (o_sync_lost !== 1'b0) begin errors++; $display("FAIL clean_sync: got %b want 0", o_sync_lost); end
  endtask

  task automatic test_junk();
    int    w;
    beat_t j;
    out_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      j.data = 24'hEE0000 + 24'(i);
      j.last = i[0];
      j.user = (i == 3) ? 2'b10 : 2'b00;
      send(j, 4, w);
      vectors++; if (w != 1) begin errors++; $display("FAIL junk_ready%0d: took %0d cycles want 1", i, w); end
    end
    drain();
    vectors++; if (out_q.size() != 0) begin errors++; $display("FAIL junk_emitted: got %0d beats want 0", out_q.size()); end
    send_range(4, 3, 8'h22, 0, 11);
    drain();
    add_exp(4, 3, 8'h22, 0, 11);
    vectors++; if (out_q.size() != 12) begin errors++; $display("FAIL junk_frame_count: got %0d want 12", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL junk_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_early_eol();
    int    w;
    beat_t b;
    out_q.delete(); exp_q.delete();
    send_range(4, 3, 8'h33, 0, 5);
    b = in_beat(4, 3, 6, 8'h33);
    b.last = 1'b1;
    send(b, 10, w);
    send_range(4, 3, 8'h33, 7, 11);
    drain();
    add_exp(4, 3, 8'h33, 0, 5);
    exp_q.push_back({24'h330006, 1'b1, 2'b10});
    vectors++; if (out_q.size() != 7) begin errors++; $display("FAIL eol_count: got %0d want 7", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL eol_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++;
    if (o_frames_dropped !== (StatsEn ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL eol_dropped: got %h want %h", o_frames_dropped, StatsEn ? 16'd1 : 16'd0);
    end
    vectors++;
    if (o_sync_lost !== StatsEn) begin errors++; $display("FAIL eol_sync: got %b want %b", o_sync_lost, StatsEn); end
    out_q.delete(); exp_q.delete();
    send_range(4, 3, 8'h34, 0, 11);
    drain();
    add_exp(4, 3, 8'h34, 0, 11);
    vectors++; if (out_q.size() != 12) begin errors++; $display("FAIL eol_next_count: got %0d want 12", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL eol_next_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stray_sof();
    out_q.delete(); exp_q.delete();
    send_range(4, 3, 8'h55, 0, 5);
    send_range(4, 3, 8'h56, 0, 11);
    drain();
    add_exp(4, 3, 8'h55, 0, 5);
    add_exp(4, 3, 8'h56, 0, 11);
    vectors++; if (out_q.size() != 18) begin errors++; $display("FAIL stray_count: got %0d want 18", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL stray_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++;
    if (o_frames_dropped !== (StatsEn ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL stray_dropped: got %h want %h", o_frames_dropped, StatsEn ? 16'd2 : 16'd0);
    end
  endtask

  task automatic test_zero_res();
    int w;
    out_q.delete(); exp_q.delete();
    i_hres = 12'd0; i_vres = 12'd3;
    send(in_beat(4, 3, 0, 8'h70), 10, w);
    send_range(4, 3, 8'h71, 0, 11);
    drain();
    add_exp(4, 3, 8'h71, 0, 11);
    vectors++; if (out_q.size() != 12) begin errors++; $display("FAIL zero_count: got %0d want 12", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++;
    if (o_frames_dropped !== (StatsEn ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL zero_dropped: got %h want %h", o_frames_dropped, StatsEn ? 16'd3 : 16'd0);
    end
  endtask

  task automatic test_back_to_back_random_ready();
    out_q.delete(); exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 10; f++) send_range(3, 2, 8'h80 + 8'(f), 0, 5);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    drain();
    for (int f = 0; f < 10; f++) add_exp(3, 2, 8'h80 + 8'(f), 0, 5);
    vectors++; if (out_q.size() != 60) begin errors++; $display("FAIL rnd_count: got %0d want 60", out_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      vectors++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_beat%0d: got %h want %h", i, out_q[i], exp_q[i]); end
    end
    vectors++; if (stall_err != 0) begin errors++; $display("FAIL rnd_stable: got %0d stall changes want 0", stall_err); end
  endtask

  task automatic test_saturation();
    int    w;
    beat_t b;
    out_q.delete();
`ifdef FRAME_ALIGNER_STATS_EN
    force dut.frames_dropped_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.frames_dropped_q;
`endif
    for (int f = 0; f < 3; f++) begin
      i_hres = 12'd4; i_vres = 12'd3;
      send(in_beat(4, 3, 0, 8'h90), 10, w);
      b = in_beat(4, 3, 1, 8'h90);
      b.last = 1'b1;
      send(b, 10, w);
      drain();
      vectors++;
      if (o_frames_dropped !== (StatsEn ? 16'hFFFF : 16'd0)) begin
        errors++; $display("FAIL sat_dropped%0d: got %h want %h", f, o_frames_dropped,
                           StatsEn ? 16'hFFFF : 16'd0);
      end
    end
    vectors++; if (out_q.size() != 6) begin errors++; $display("FAIL sat_count: got %0d want 6", out_q.size()); end
    vectors++;
    if (out_q.size() >= 2 && out_q[1] !== {24'h900001, 1'b1, 2'b10}) begin
      errors++; $display("FAIL sat_trunc_beat: got %h want %h", out_q[1], {24'h900001, 1'b1, 2'b10});
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_junk();
    test_early_eol();
    test_stray_sof();
    test_zero_res();
    test_back_to_back_random_ready();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
